// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants, depth helper and stage record for the pipelined CLA adder
package cla_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_GROUP = 8;

  // Pipeline depth; a zero group size is rejected at elaboration, 1 keeps the divide safe meanwhile.
  function automatic int ngrp(input int w, input int g);
    return (g < 1) ? 1 : w / g;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic                 sub;
    logic                 carry;
    logic [DEF_WIDTH-1:0] a_rem;
    logic [DEF_WIDTH-1:0] b_rem;
    logic [DEF_WIDTH-1:0] sum_acc;
  } cla_stage_t;

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational carry-lookahead group with full lookahead carries
module cla_group #(
  parameter int GROUP = 8
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             c_msb,
  output logic             gg,
  output logic             pg
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;

  assign g = a & b;
  assign p = a | b;

  // Each carry is a flat sum-of-products over g/p/cin, so no carry depends on another carry.
  always_comb begin
    logic acc;
    logic term;
    c    = '0;
    acc  = 1'b0;
    term = 1'b0;
    for (int i = 0; i <= GROUP; i++) begin
      acc = cin;
      for (int j = 0; j < i; j++) acc = acc & p[j];
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        acc = acc | term;
      end
      c[i] = acc;
    end
  end

  always_comb begin
    logic term;
    gg   = 1'b0;
    term = 1'b0;
    for (int j = 0; j < GROUP; j++) begin
      term = g[j];
      for (int m = j + 1; m < GROUP; m++) term = term & p[m];
      gg = gg | term;
    end
  end

  assign pg    = &p;
  assign sum   = a ^ b ^ c[GROUP-1:0];
  assign cout  = c[GROUP];
  assign c_msb = c[GROUP-1];

endmodule

// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - pipelined carry-lookahead adder/subtractor, one lookahead group per stage
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NGRP = ngrp(WIDTH, GROUP);

  if (GROUP < 1 || GROUP > 8 || (WIDTH % ((GROUP < 1) ? 1 : GROUP)) != 0) begin : g_bad_param
    $error("cla_adder_pipe: WIDTH must be a multiple of GROUP and GROUP must be 1..8");
  end

  typedef struct packed {
    logic             valid;
    logic             sub;
    logic             carry;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] sum_acc;
  } stage_t;

  logic   adv;
  stage_t src [NGRP];

  // The whole pipe moves in lockstep; the only stall source is an unaccepted result.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign src[0].valid   = in_valid;
  assign src[0].sub     = in_sub;
  assign src[0].carry   = in_sub | in_cin;
  assign src[0].a_rem   = in_a;
  assign src[0].b_rem   = in_b;
  assign src[0].sum_acc = '0;

  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    logic [GROUP-1:0] ga;
    logic [GROUP-1:0] gb;
    logic [GROUP-1:0] gs;
    logic             gco;
    logic             gcm;
    logic             ggen;
    logic             gprop;

    // Operand slices are shifted down each stage, so the current group always sits at bit 0.
    assign ga = src[k].a_rem[GROUP-1:0];
    assign gb = src[k].b_rem[GROUP-1:0] ^ {GROUP{src[k].sub}};

    cla_group #(.GROUP(GROUP)) u_grp (
      .a     (ga),
      .b     (gb),
      .cin   (src[k].carry),
      .sum   (gs),
      .cout  (gco),
      .c_msb (gcm),
      .gg    (ggen),
      .pg    (gprop)
    );

    if (k < NGRP - 1) begin : g_mid
      stage_t q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
        end else if (adv) begin
          q.valid   <= src[k].valid;
          q.sub     <= src[k].sub;
          q.carry   <= gco;
          q.a_rem   <= src[k].a_rem >> GROUP;
          q.b_rem   <= src[k].b_rem >> GROUP;
          q.sum_acc <= src[k].sum_acc | (WIDTH'(gs) << (k * GROUP));
        end
      end

      assign src[k+1] = q;
    end else begin : g_last
      logic [WIDTH-1:0] sum_full;

      assign sum_full = src[k].sum_acc | (WIDTH'(gs) << (k * GROUP));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          out_sum   <= '0;
          out_cout  <= 1'b0;
          out_ovf   <= 1'b0;
          out_zero  <= 1'b0;
        end else if (adv) begin
          out_valid <= src[k].valid;
          out_sum   <= sum_full;
          out_cout  <= gco;
          out_ovf   <= gcm ^ gco;
          out_zero  <= ~|sum_full;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb/tb_cla_adder_pipe.sv - self-checking bench for cla_adder_pipe at 32/8, 16/4 and 8/8
module tb_cla_adder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_sub, in_cin, out_ready;
  logic [31:0] in_a, in_b;
  logic        rdy [3];
  logic        ov  [3];
  logic        oc  [3];
  logic        oo  [3];
  logic        oz  [3];
  logic [31:0] os32;
  logic [15:0] os16;
  logic [7:0]  os8;

  int errors = 0;
  int checks = 0;
  int wid [3] = '{32, 16, 8};
  int dep [3] = '{4, 4, 1};

  logic [34:0] sbq [3][$];
  logic        ifire [3];
  logic        ofire [3];
  logic [34:0] obs   [3];

  always #5 clk = ~clk;

  cla_adder_pipe #(.WIDTH(32), .GROUP(8)) d32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_sub(in_sub),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(ov[0]), .out_ready(out_ready),
    .out_sum(os32), .out_cout(oc[0]), .out_ovf(oo[0]), .out_zero(oz[0]));

  cla_adder_pipe #(.WIDTH(16), .GROUP(4)) d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_sub(in_sub),
    .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_cin(in_cin), .out_valid(ov[1]), .out_ready(out_ready),
    .out_sum(os16), .out_cout(oc[1]), .out_ovf(oo[1]), .out_zero(oz[1]));

  cla_adder_pipe #(.WIDTH(8), .GROUP(8)) d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_sub(in_sub),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_cin(in_cin), .out_valid(ov[2]), .out_ready(out_ready),
    .out_sum(os8), .out_cout(oc[2]), .out_ovf(oo[2]), .out_zero(oz[2]));

  // Reference: {zero, ovf, cout, sum} from wide integer arithmetic and operand sign bits.
  function automatic logic [34:0] model(input int w, input logic s, input logic [31:0] a,
                                        input logic [31:0] b, input logic ci);
    logic [63:0] mask, am, bm, full;
    logic [31:0] sm;
    logic        co, vf;
    mask = (64'd1 << w) - 64'd1;
    am   = {32'b0, a} & mask;
    bm   = (s ? ~{32'b0, b} : {32'b0, b}) & mask;
    full = am + bm + (s ? 64'd1 : {63'b0, ci});
    sm   = 32'(full & mask);
    co   = full[w];
    vf   = (am[w-1] == bm[w-1]) && (sm[w-1] != am[w-1]);
    return {sm == 32'd0, vf, co, sm};
  endfunction

  function automatic logic [34:0] cur(input int i);
    case (i)
      0:       return {oz[0], oo[0], oc[0], os32};
      1:       return {oz[1], oo[1], oc[1], 16'b0, os16};
      default: return {oz[2], oo[2], oc[2], 24'b0, os8};
    endcase
  endfunction

  // One clock: sample handshakes at the falling edge, then move to just after the rising edge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ifire[i] = in_valid && rdy[i];
      ofire[i] = ov[i] && out_ready;
      obs[i]   = cur(i);
      if (ifire[i]) sbq[i].push_back(model(wid[i], in_sub, in_a, in_b, in_cin));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op();
    in_sub = 1'($urandom % 2);
    in_cin = 1'($urandom % 2);
    in_a   = $urandom;
    in_b   = $urandom;
  endtask

  task automatic drain_silent();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) step();
    for (int i = 0; i < 3; i++) sbq[i].delete();
  endtask

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, output int l);
    in_valid = 1'b1; in_sub = s; in_a = a; in_b = b; in_cin = ci; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    l = 0;
    while (!ov[0] && l < 20) begin
      step();
      l++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sub = 1'b0; in_cin = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ov[i] !== 1'b0) begin errors++; $display("FAIL reset_out_valid inst%0d got=%b exp=0", i, ov[i]); end
      checks++;
      if (rdy[i] !== 1'b1) begin errors++; $display("FAIL reset_in_ready inst%0d got=%b exp=1", i, rdy[i]); end
      checks++;
      if (cur(i) !== 35'd0) begin errors++; $display("FAIL reset_outputs inst%0d got=%h exp=0", i, cur(i)); end
    end
  endtask

  task automatic test_add();
    logic [31:0] ta [3] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000001};
    logic [31:0] tb [3] = '{32'h00000001, 32'h00000001, 32'h00000001};
    logic        tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] es [3] = '{32'h00000000, 32'h80000000, 32'h00000003};
    logic        ec [3] = '{1'b1, 1'b0, 1'b0};
    logic        eo [3] = '{1'b0, 1'b1, 1'b0};
    logic        ez [3] = '{1'b1, 1'b0, 1'b0};
    int          l;
    for (int v = 0; v < 3; v++) begin
      issue(1'b0, ta[v], tb[v], tc[v], l);
      checks++;
      if (l !== 3) begin errors++; $display("FAIL add_latency v%0d got=%0d exp=3", v, l); end
      checks++;
      if (os32 !== es[v]) begin errors++; $display("FAIL add_sum v%0d got=%h exp=%h", v, os32, es[v]); end
      checks++;
      if (oc[0] !== ec[v]) begin errors++; $display("FAIL add_cout v%0d got=%b exp=%b", v, oc[0], ec[v]); end
      checks++;
      if (oo[0] !== eo[v]) begin errors++; $display("FAIL add_ovf v%0d got=%b exp=%b", v, oo[0], eo[v]); end
      checks++;
      if (oz[0] !== ez[v]) begin errors++; $display("FAIL add_zero v%0d got=%b exp=%b", v, oz[0], ez[v]); end
      drain_silent();
    end
  endtask

  task automatic test_sub();
    logic [31:0] ta [2] = '{32'h80000000, 32'h00000005};
    logic [31:0] tb [2] = '{32'h00000001, 32'h00000007};
    logic [31:0] es [2] = '{32'h7FFFFFFF, 32'hFFFFFFFE};
    logic        ec [2] = '{1'b1, 1'b0};
    logic        eo [2] = '{1'b1, 1'b0};
    int          l;
    for (int v = 0; v < 2; v++) begin
      issue(1'b1, ta[v], tb[v], 1'b1, l);
      checks++;
      if (l !== 3) begin errors++; $display("FAIL sub_latency v%0d got=%0d exp=3", v, l); end
      checks++;
      if (os32 !== es[v]) begin errors++; $display("FAIL sub_sum v%0d got=%h exp=%h", v, os32, es[v]); end
      checks++;
      if (oc[0] !== ec[v]) begin errors++; $display("FAIL sub_cout v%0d got=%b exp=%b", v, oc[0], ec[v]); end
      checks++;
      if (oo[0] !== eo[v]) begin errors++; $display("FAIL sub_ovf v%0d got=%b exp=%b", v, oo[0], eo[v]); end
      checks++;
      if (oz[0] !== 1'b0) begin errors++; $display("FAIL sub_zero v%0d got=%b exp=0", v, oz[0]); end
      drain_silent();
    end
  endtask

  task automatic test_back_to_back(input int nops, input string tag);
    logic [34:0] e;
    int          nout [3] = '{0, 0, 0};
    out_ready = 1'b1;
    for (int n = 0; n < nops; n++) begin
      in_valid = 1'b1;
      rand_op();
      step();
      for (int i = 0; i < 3; i++) if (ofire[i]) begin
        nout[i]++;
        checks++;
        if (sbq[i].size() == 0) begin
          errors++; $display("FAIL %s_extra inst%0d got=%h exp=none", tag, i, obs[i]);
        end else begin
          e = sbq[i].pop_front();
          if (obs[i] !== e) begin errors++; $display("FAIL %s_result inst%0d got=%h exp=%h", tag, i, obs[i], e); end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (nout[i] !== nops - dep[i]) begin
        errors++; $display("FAIL %s_throughput inst%0d got=%0d exp=%0d", tag, i, nout[i], nops - dep[i]);
      end
    end
    in_valid = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step();
      for (int i = 0; i < 3; i++) if (ofire[i]) begin
        checks++;
        if (sbq[i].size() == 0) begin
          errors++; $display("FAIL %s_extra inst%0d got=%h exp=none", tag, i, obs[i]);
        end else begin
          e = sbq[i].pop_front();
          if (obs[i] !== e) begin errors++; $display("FAIL %s_result inst%0d got=%h exp=%h", tag, i, obs[i], e); end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sbq[i].size() != 0) begin errors++; $display("FAIL %s_lost inst%0d got=%0d exp=0", tag, i, sbq[i].size()); end
    end
  endtask

  task automatic test_stall();
    logic [34:0] held;
    logic [34:0] e;
    out_ready = 1'b0;
    for (int n = 0; n < 8; n++) begin
      in_valid = 1'b1;
      rand_op();
      step();
    end
    checks++;
    if (ov[0] !== 1'b1) begin errors++; $display("FAIL stall_full got=%b exp=1", ov[0]); end
    held = cur(0);
    for (int n = 0; n < 3; n++) begin
      rand_op();
      step();
      checks++;
      if (rdy[0] !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d got=%b exp=0", n, rdy[0]); end
      checks++;
      if (cur(0) !== held) begin errors++; $display("FAIL stall_hold c%0d got=%h exp=%h", n, cur(0), held); end
    end
    checks++;
    if (sbq[0].size() != 4) begin errors++; $display("FAIL stall_accepted got=%0d exp=4", sbq[0].size()); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      for (int i = 0; i < 3; i++) if (ofire[i]) begin
        checks++;
        if (sbq[i].size() == 0) begin
          errors++; $display("FAIL stall_extra inst%0d got=%h exp=none", i, obs[i]);
        end else begin
          e = sbq[i].pop_front();
          if (obs[i] !== e) begin errors++; $display("FAIL stall_result inst%0d got=%h exp=%h", i, obs[i], e); end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sbq[i].size() != 0) begin errors++; $display("FAIL stall_lost inst%0d got=%0d exp=0", i, sbq[i].size()); end
    end
  endtask

  task automatic test_random_gaps();
    logic [34:0] e;
    for (int n = 0; n < 400; n++) begin
      in_valid  = (n < 360) ? 1'($urandom % 2) : 1'b0;
      out_ready = (n < 360) ? ($urandom_range(0, 2) != 0) : 1'b1;
      rand_op();
      step();
      for (int i = 0; i < 3; i++) if (ofire[i]) begin
        checks++;
        if (sbq[i].size() == 0) begin
          errors++; $display("FAIL gaps_extra inst%0d got=%h exp=none", i, obs[i]);
        end else begin
          e = sbq[i].pop_front();
          if (obs[i] !== e) begin errors++; $display("FAIL gaps_result inst%0d got=%h exp=%h", i, obs[i], e); end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sbq[i].size() != 0) begin errors++; $display("FAIL gaps_lost inst%0d got=%0d exp=0", i, sbq[i].size()); end
    end
  endtask

  task automatic test_reset_midflight();
    int nout = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1;
      rand_op();
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ov[i] !== 1'b0) begin errors++; $display("FAIL midrst_valid inst%0d got=%b exp=0", i, ov[i]); end
      sbq[i].delete();
    end
    step();
    step();
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step();
      for (int i = 0; i < 3; i++) if (ofire[i]) nout++;
    end
    checks++;
    if (nout != 0) begin errors++; $display("FAIL midrst_stale got=%0d exp=0", nout); end
    test_back_to_back(20, "postrst");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back(1000, "b2b");
    test_stall();
    test_random_gaps();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
